// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit.
// A radix-2 shift-add multiplier and a restoring divider share one
// 2*XLEN accumulator. A five-state FSM sequences each op:
//   IDLE -> PREP -> CALC (XLEN cycles) -> FIX -> DONE
// Divide-by-zero and signed overflow are resolved in PREP and go straight
// to DONE. flush aborts from any state.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_func3,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic [4:0]      req_rd,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd,
    output logic            busy
);

    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [2:0] F_MUL    = 3'd0;
    localparam logic [2:0] F_MULH   = 3'd1;
    localparam logic [2:0] F_MULHSU = 3'd2;
    localparam logic [2:0] F_MULHU  = 3'd3;
    localparam logic [2:0] F_DIV    = 3'd4;
    localparam logic [2:0] F_DIVU   = 3'd5;
    localparam logic [2:0] F_REM    = 3'd6;
    localparam logic [2:0] F_REMU   = 3'd7;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // Latched request
    logic [2:0]        func3_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [4:0]        rd_q;

    // Working state
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   mag_b;
    logic [2*XLEN-1:0] acc;
    logic [CW-1:0]     count;

    // Operand decode of the latched request
    logic              is_div;
    logic              op_signed_a;
    logic              op_signed_b;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              div_by_zero;
    logic              div_ovf;
    logic              special;
    logic [XLEN-1:0]   special_result;

    // One iteration of each algorithm
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_trial;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] div_next;

    // Sign fix-up and result select
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   result;

    logic              accept;

    assign accept = (state == S_IDLE) && req_valid && !flush;

    // MUL low word is sign-independent, so it is treated as unsigned.
    assign is_div      = func3_q[2];
    assign op_signed_a = (func3_q == F_MULH) || (func3_q == F_MULHSU) ||
                         (func3_q == F_DIV)  || (func3_q == F_REM);
    assign op_signed_b = (func3_q == F_MULH) || (func3_q == F_DIV) || (func3_q == F_REM);
    assign a_neg       = op_signed_a && a_q[XLEN-1];
    assign b_neg       = op_signed_b && b_q[XLEN-1];
    assign a_mag       = a_neg ? -a_q : a_q;
    assign b_mag       = b_neg ? -b_q : b_q;

    assign div_by_zero = is_div && (b_q == '0);
    assign div_ovf     = ((func3_q == F_DIV) || (func3_q == F_REM)) &&
                         (a_q == MIN_NEG) && (b_q == '1);
    assign special     = div_by_zero || div_ovf;

    // func3[1] separates the remainder ops (6,7) from the quotient ops (4,5).
    assign special_result = div_by_zero ? (func3_q[1] ? a_q : '1)
                                        : (func3_q[1] ? '0  : MIN_NEG);

    // Multiply: the multiplier sits in the low half and is consumed from bit 0;
    // the partial product grows in the high half. Keep the carry-out.
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
    assign mul_next = {mul_sum, acc[XLEN-1:1]};

    // Divide: high half is the remainder, low half shifts the dividend out at
    // the top and the quotient in at the bottom. The trial needs XLEN+1 bits
    // because a remainder just below a large divisor overflows on shift.
    // When div_ge holds the true difference fits in XLEN bits.
    assign div_trial = acc[2*XLEN-1:XLEN-1];
    assign div_ge    = div_trial >= {1'b0, mag_b};
    assign div_rem   = div_ge ? (div_trial[XLEN-1:0] - mag_b) : div_trial[XLEN-1:0];
    assign div_next  = {div_rem, acc[XLEN-2:0], div_ge};

    assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    assign quo_fix  = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem_fix  = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

    // Select the architectural result for the latched func3.
    always_comb begin
        result = prod_fix[XLEN-1:0];
        case (func3_q)
            F_MUL:                      result = prod_fix[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:              result = quo_fix;
            F_REM, F_REMU:              result = rem_fix;
            default:                    result = prod_fix[XLEN-1:0];
        endcase
    end

    // State register.
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs; flush overrides every transition.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = S_PREP;
            end
            S_PREP: state_nxt = special ? S_DONE : S_CALC;
            S_CALC: if (count == CW'(XLEN - 1)) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
            S_DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    // Datapath: latch the request, prepare magnitudes, iterate, fix signs.
    // NOTE: every register here, including the result outputs, is cleared by
    // the async reset so nothing stale is visible after rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func3_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            mag_b     <= '0;
            acc       <= '0;
            count     <= '0;
            resp_data <= '0;
            resp_rd   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        func3_q <= req_func3;
                        a_q     <= req_a;
                        b_q     <= req_b;
                        rd_q    <= req_rd;
                    end
                end
                S_PREP: begin
                    sign_a <= a_neg;
                    sign_b <= b_neg;
                    mag_b  <= b_mag;
                    acc    <= {{XLEN{1'b0}}, a_mag};
                    count  <= '0;
                    if (special && !flush) begin
                        resp_data <= special_result;
                        resp_rd   <= rd_q;
                    end
                end
                S_CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    if (count != CW'(XLEN - 1)) count <= count + 1'b1;
                end
                S_FIX: begin
                    if (!flush) begin
                        resp_data <= result;
                        resp_rd   <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed RV32M cases, special-case
// divides, backpressure, flush, reset mid-op, and randomized ops compared
// against an arithmetic reference model.
module tb_muldiv_seq;

    localparam int XLEN     = 32;
    localparam int LAT_NORM = XLEN + 2;
    localparam int LAT_SPEC = 1;
    localparam int TIMEOUT  = 200;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [2:0]      req_func3 = '0;
    logic [XLEN-1:0] req_a = '0;
    logic [XLEN-1:0] req_b = '0;
    logic [4:0]      req_rd = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [XLEN-1:0] resp_data;
    logic [4:0]      resp_rd;
    logic            busy;

    int errors = 0;
    int checks = 0;

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_func3  (req_func3),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_rd     (req_rd),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // RV32M semantics straight from the ISA rules, using wide arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = 64'(longint'($signed(a)) * longint'($signed(b))); return p[63:32]; end
            3'd2: begin p = 64'(longint'($signed(a)) * longint'({32'b0, b})); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f >= 3'd4 && b == 0) return LAT_SPEC;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LAT_SPEC;
        return LAT_NORM;
    endfunction

    // Present one request for exactly one accept edge, then scramble the bus.
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        req_valid = 1'b1;
        req_func3 = f;
        req_a     = a;
        req_b     = b;
        req_rd    = rd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        req_rd    = 5'($urandom);
    endtask

    // Bounded wait for resp_valid; returns cycles since the accept edge.
    task automatic wait_resp(output int lat);
        lat = 0;
        while (resp_valid !== 1'b1 && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Full transaction: accept, latency, data, rd, then writeback handshake.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        start_op(f, a, b, rd);
        wait_resp(lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, resp_data, exp);
        check({tag, "_rd"}, 32'(resp_rd), 32'(rd));
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({tag, "_idle_after"}, 32'({resp_valid, busy, req_ready}), 32'b001);
    endtask

    initial begin
        int lat;
        int seen;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;

        // Reset state
        #2;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_outputs", 32'({resp_valid, busy}), 32'd0);
        check("rst_data", resp_data, 32'd0);
        check("rst_rd", 32'(resp_rd), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic
        run_op("mul_7_m3",  3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, LAT_NORM);
        run_op("mulh",      3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, LAT_NORM);
        run_op("mulhsu",    3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h8000_0000, LAT_NORM);
        run_op("mulhu",     3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h7FFF_FFFF, LAT_NORM);
        run_op("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, LAT_NORM);
        run_op("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, LAT_NORM);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd7, 32'd14, LAT_NORM);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd8, 32'd2, LAT_NORM);

        // Special-case divides resolve in PREP
        run_op("div_5_0",   3'd4, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, LAT_SPEC);
        run_op("remu_5_0",  3'd7, 32'd5, 32'd0, 5'd11, 32'd5, LAT_SPEC);
        run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, LAT_SPEC);
        run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0, LAT_SPEC);

        // Backpressure: result held stable, no accept while in DONE
        start_op(3'd5, 32'd100, 32'd7, 5'd9);
        wait_resp(lat);
        check("bp_latency", 32'(lat), 32'(LAT_NORM));
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_data", resp_data, 32'd14);
            check("bp_rd", 32'(resp_rd), 32'd9);
            check("bp_hs", 32'({resp_valid, req_ready}), 32'b10);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("bp_release", 32'({resp_valid, busy, req_ready}), 32'b001);

        // flush && req_valid in IDLE: not accepted
        flush     = 1'b1;
        req_valid = 1'b1;
        @(posedge clk); #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        check("idle_flush_noaccept", 32'(busy), 32'd0);

        // flush at CALC count=10
        start_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd14);
        repeat (11) begin @(posedge clk); #1; end
        check("calc_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("calc_flush_idle", 32'({resp_valid, busy, req_ready}), 32'b001);
        seen = 0;
        repeat (LAT_NORM + 4) begin
            @(posedge clk); #1;
            if (resp_valid === 1'b1) seen++;
        end
        check("calc_flush_no_resp", 32'(seen), 32'd0);
        run_op("post_flush", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15,
               ref_result(3'd1, 32'h1234_5678, 32'h9ABC_DEF0), LAT_NORM);

        // flush in DONE coincident with resp_ready: flush wins
        start_op(3'd4, 32'd5, 32'd0, 5'd16);
        @(posedge clk); #1;
        check("done_reached", 32'(resp_valid), 32'd1);
        flush      = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        flush      = 1'b0;
        resp_ready = 1'b0;
        check("done_flush", 32'({resp_valid, busy, req_ready}), 32'b001);

        // rst_n pulse mid-CALC
        start_op(3'd6, 32'hDEAD_BEEF, 32'h0000_1234, 5'd17);
        repeat (15) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #2;
        check("midrst_state", 32'({resp_valid, busy, req_ready}), 32'b001);
        check("midrst_data", resp_data, 32'd0);
        check("midrst_rd", 32'(resp_rd), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op("post_reset", 3'd6, 32'hDEAD_BEEF, 32'h0000_1234, 5'd17,
               ref_result(3'd6, 32'hDEAD_BEEF, 32'h0000_1234), LAT_NORM);

        // Randomized ops against the reference model, biased toward corners
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'h8000_0000;
                default: ;
            endcase
            run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b, 5'($urandom),
                   ref_result(f, a, b), ref_latency(f, a, b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
